// File: rtl/gamepad_pkg.sv
// Shared definitions for the gamepad move controller: direction codes,
// controller FSM state encoding and bit positions in the raw button vector.
package gamepad_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic {
    ARMED = 1'b0,
    HELD  = 1'b1
  } move_state_e;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_START = 4;
  localparam int BTN_W     = 5;

  // Maps a one-hot {right,left,down,up} vector to its move code.
  function automatic logic [1:0] dir_code(input logic [3:0] dirs);
    logic [1:0] code;
    code = DIR_UP;
    case (dirs)
      4'b0001: code = DIR_UP;
      4'b0010: code = DIR_DOWN;
      4'b0100: code = DIR_LEFT;
      4'b1000: code = DIR_RIGHT;
      default: code = DIR_UP;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/gamepad_move_ctrl_if.sv
// Move handshake between the gamepad controller (master) and board-update logic (slave).
// valid/ready: a move transfers on a clk edge where move_valid & move_ready; move_valid
// never depends on move_ready, and move_dir is meaningful only while move_valid=1.
interface gamepad_move_ctrl_if;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       move_ready;

  modport master (output move_valid, output move_dir, input move_ready);
  modport slave  (input move_valid, input move_dir, output move_ready);
endinterface

// File: rtl/move_fifo.sv
// First-word-fall-through FIFO with flush; rdata reads as zero while empty.
// A push while full only succeeds when a pop frees a slot in the same cycle.
module move_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & ~flush & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/gamepad_move_ctrl.sv
// Frame-sampled, debounced gamepad buttons turned into single 2048 move commands
// (one per distinct direction press) plus a new-game pulse on START.
module gamepad_move_ctrl
  import gamepad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int FIFO_DEPTH      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_tick,
  input  logic                        is_present,
  input  logic                        btn_up,
  input  logic                        btn_down,
  input  logic                        btn_left,
  input  logic                        btn_right,
  input  logic                        btn_start,
  gamepad_move_ctrl_if.master         mv,
  output logic                        new_game,
  output logic                        move_drop,
  output move_state_e                 fsm_state
);

  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES - 1);

  logic [BTN_W-1:0] raw;
  logic [BTN_W-1:0] last_r;
  logic [BTN_W-1:0] db;
  logic [BTN_W-1:0] db_prev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0]       dirs;
  logic             start_rise;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       fifo_head;
  move_state_e      state;
  move_state_e      state_nxt;

  // A disconnected controller reads as all buttons released.
  assign raw = {btn_start, btn_right, btn_left, btn_down, btn_up} & {BTN_W{is_present}};

  // cnt counts how many consecutive ticks beyond the first r has stayed unchanged.
  always_comb begin
    cnt_nxt = '0;
    if (raw == last_r) begin
      cnt_nxt = (cnt >= CNT_MAX) ? CNT_MAX : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r  <= '0;
      cnt     <= '0;
      db      <= '0;
      db_prev <= '0;
    end else begin
      db_prev <= db;
      if (frame_tick) begin
        last_r <= raw;
        cnt    <= cnt_nxt;
        if (cnt_nxt >= CNT_MAX) db <= raw;
      end
    end
  end

  assign dirs       = db[BTN_RIGHT:BTN_UP];
  assign start_rise = db[BTN_START] & ~db_prev[BTN_START];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARMED;
    else        state <= state_nxt;
  end

  // START outranks any direction push decided in the same cycle.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    if (start_rise) begin
      state_nxt = HELD;
    end else begin
      case (state)
        ARMED: begin
          if ($onehot(dirs)) begin
            push      = 1'b1;
            state_nxt = HELD;
          end
        end
        HELD: begin
          if (dirs == 4'b0000) state_nxt = ARMED;
        end
        default: state_nxt = ARMED;
      endcase
    end
  end

  assign pop = ~fifo_empty & mv.move_ready;

  move_fifo #(
    .WIDTH (2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (start_rise),
    .push  (push),
    .wdata (dir_code(dirs)),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky overflow flag; a pop in the same cycle makes room, so that is not a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          move_drop <= 1'b0;
    else if (start_rise)                 move_drop <= 1'b0;
    else if (push & fifo_full & ~pop)    move_drop <= 1'b1;
  end

  assign mv.move_valid = ~fifo_empty;
  assign mv.move_dir   = fifo_head;
  assign new_game      = start_rise;
  assign fsm_state     = state;

endmodule

// File: tb/tb_gamepad_move_ctrl.sv
// Directed and randomized bench for gamepad_move_ctrl against a queue-based
// reference model derived from the press/debounce/FIFO rules.
module tb_gamepad_move_ctrl;
  import gamepad_pkg::*;

  localparam int DF        = 2;
  localparam int DEPTH     = 2;
  localparam int FRAME_CYC = 4;

  // clock / reset
  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic frame_tick = 1'b0;
  logic is_present = 1'b1;
  logic btn_up     = 1'b0;
  logic btn_down   = 1'b0;
  logic btn_left   = 1'b0;
  logic btn_right  = 1'b0;
  logic btn_start  = 1'b0;
  logic        new_game;
  logic        move_drop;
  move_state_e fsm_state;

  gamepad_move_ctrl_if mv();

  gamepad_move_ctrl #(
    .DEBOUNCE_FRAMES (DF),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .is_present (is_present),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_start  (btn_start),
    .mv         (mv),
    .new_game   (new_game),
    .move_drop  (move_drop),
    .fsm_state  (fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [1:0] exp_q[$];
  logic [4:0] hist[$];
  logic [4:0] m_db;
  logic [4:0] m_db_prev;
  logic       m_armed;
  logic       m_drop;
  logic [1:0] acc_q[$];
  int         ng_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] dir_of(input logic [3:0] d);
    for (int i = 0; i < 4; i++) if (d[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    hist.delete();
    m_db      = '0;
    m_db_prev = '0;
    m_armed   = 1'b1;
    m_drop    = 1'b0;
  endtask

  // Advances the model across one clock edge using the inputs held before it.
  task automatic model_edge();
    logic [4:0] r;
    logic [3:0] d;
    logic       rise;
    logic       pop;
    logic       push;
    logic       stable;
    if (!rst_n) begin
      model_reset();
      return;
    end
    r    = {btn_start, btn_right, btn_left, btn_down, btn_up} & {5{is_present}};
    d    = m_db[3:0];
    rise = m_db[4] & ~m_db_prev[4];
    pop  = (exp_q.size() > 0) && mv.move_ready;
    push = m_armed && ($countones(d) == 1) && !rise;
    if (rise) begin
      exp_q.delete();
      m_drop  = 1'b0;
      m_armed = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(dir_of(d));
        else m_drop = 1'b1;
      end
      if (m_armed && $countones(d) == 1) m_armed = 1'b0;
      else if (!m_armed && d == 4'b0000) m_armed = 1'b1;
    end
    m_db_prev = m_db;
    if (frame_tick) begin
      hist.push_back(r);
      if (hist.size() > DF) void'(hist.pop_front());
      stable = (hist.size() == DF);
      foreach (hist[i]) if (hist[i] != r) stable = 1'b0;
      if (stable) m_db = r;
    end
  endtask

  task automatic check_outputs();
    check("move_valid", mv.move_valid, exp_q.size() > 0);
    check("move_dir", mv.move_dir, (exp_q.size() > 0) ? exp_q[0] : 2'd0);
    check("new_game", new_game, m_db[4] & ~m_db_prev[4]);
    check("move_drop", move_drop, m_drop);
    check("fsm_state", fsm_state, m_armed ? ARMED : HELD);
  endtask

  // driver: one clock cycle, entered and left on a falling edge
  task automatic step(input logic tick, input logic ready);
    frame_tick    = tick;
    mv.move_ready = ready;
    check_outputs();
    if (mv.move_valid && ready) acc_q.push_back(mv.move_dir);
    if (new_game) ng_count++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // rmode: 0 = ready low, 1 = ready high, 2 = random ready each cycle
  task automatic frames(input logic [4:0] b, input int n, input int rmode, input logic pres);
    {btn_start, btn_right, btn_left, btn_down, btn_up} = b;
    is_present = pres;
    for (int f = 0; f < n; f++) begin
      for (int c = 0; c < FRAME_CYC; c++) begin
        step(c == 0, (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1));
      end
    end
  endtask

  localparam logic [4:0] B_UP = 5'b00001, B_DOWN = 5'b00010, B_LEFT = 5'b00100,
                         B_RIGHT = 5'b01000, B_START = 5'b10000, B_NONE = 5'b00000;

  initial begin
    logic [4:0] b;
    int         p;
    model_reset();
    ng_count      = 0;
    mv.move_ready = 1'b0;
    @(negedge clk);
    check("reset_valid", mv.move_valid, 1'b0);
    check("reset_dir", mv.move_dir, 2'd0);
    check("reset_new_game", new_game, 1'b0);
    check("reset_drop", move_drop, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst_n = 1'b1;

    // UP tap: one move held until accepted
    acc_q.delete();
    frames(B_UP, 3, 0, 1'b1);
    frames(B_NONE, 3, 0, 1'b1);
    check("tap_valid_held", mv.move_valid, 1'b1);
    check("tap_dir", mv.move_dir, DIR_UP);
    frames(B_NONE, 1, 1, 1'b1);
    check("tap_count", acc_q.size(), 1);

    // LEFT long hold, release, press again
    acc_q.delete();
    frames(B_LEFT, 20, 1, 1'b1);
    frames(B_NONE, 3, 1, 1'b1);
    frames(B_LEFT, 3, 1, 1'b1);
    frames(B_NONE, 3, 1, 1'b1);
    check("left_count", acc_q.size(), 2);
    foreach (acc_q[i]) check("left_dir", acc_q[i], DIR_LEFT);

    // roll RIGHT -> RIGHT+UP -> RIGHT, then a two-key chord from idle
    acc_q.delete();
    frames(B_RIGHT, 3, 1, 1'b1);
    frames(B_RIGHT | B_UP, 3, 1, 1'b1);
    frames(B_RIGHT, 3, 1, 1'b1);
    frames(B_NONE, 3, 1, 1'b1);
    check("roll_count", acc_q.size(), 1);
    foreach (acc_q[i]) check("roll_dir", acc_q[i], DIR_RIGHT);
    acc_q.delete();
    frames(B_UP | B_RIGHT, 3, 1, 1'b1);
    frames(B_NONE, 3, 1, 1'b1);
    check("chord_count", acc_q.size(), 0);

    // three DOWN presses into a two-entry FIFO
    acc_q.delete();
    for (int k = 0; k < 3; k++) begin
      frames(B_DOWN, 3, 0, 1'b1);
      frames(B_NONE, 3, 0, 1'b1);
    end
    check("overflow_drop", move_drop, 1'b1);
    check("overflow_valid", mv.move_valid, 1'b1);
    frames(B_NONE, 2, 1, 1'b1);
    check("overflow_count", acc_q.size(), 2);
    foreach (acc_q[i]) check("overflow_dir", acc_q[i], DIR_DOWN);
    check("overflow_drained", mv.move_valid, 1'b0);

    // START with two moves queued flushes and clears the drop flag
    frames(B_UP, 3, 0, 1'b1);
    frames(B_NONE, 3, 0, 1'b1);
    frames(B_LEFT, 3, 0, 1'b1);
    frames(B_NONE, 3, 0, 1'b1);
    check("start_queued", mv.move_valid, 1'b1);
    ng_count = 0;
    frames(B_START, 3, 0, 1'b1);
    check("start_pulses", ng_count, 1);
    check("start_flush_valid", mv.move_valid, 1'b0);
    check("start_flush_drop", move_drop, 1'b0);
    frames(B_NONE, 3, 1, 1'b1);

    // controller absent while RIGHT is asserted
    acc_q.delete();
    frames(B_RIGHT, 4, 1, 1'b0);
    frames(B_NONE, 3, 1, 1'b1);
    check("absent_count", acc_q.size(), 0);

    // asynchronous reset with a move queued
    frames(B_UP, 3, 0, 1'b1);
    frames(B_NONE, 2, 0, 1'b1);
    check("prereset_valid", mv.move_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", mv.move_valid, 1'b0);
    check("async_dir", mv.move_dir, 2'd0);
    check("async_new_game", new_game, 1'b0);
    check("async_drop", move_drop, 1'b0);
    @(negedge clk);
    model_reset();
    step(1'b0, 1'b0);
    rst_n = 1'b1;
    frames(B_NONE, 2, 1, 1'b1);

    // randomized button traffic against the model
    for (int it = 0; it < 150; it++) begin
      p = $urandom_range(0, 9);
      if (p <= 4)      b = 5'(1 << $urandom_range(0, 3));
      else if (p <= 6) b = B_NONE;
      else if (p == 7) b = 5'(1 << $urandom_range(0, 3)) | 5'(1 << $urandom_range(0, 3));
      else if (p == 8) b = ($urandom_range(0, 3) == 0) ? B_START : B_NONE;
      else             b = 5'($urandom_range(0, 31));
      frames(b, $urandom_range(1, 4), 2, 1'($urandom_range(0, 7) != 0));
    end
    frames(B_NONE, 3, 1, 1'b1);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
